// File: rtl/piso_serializer_if.sv
// Word-in / bit-out handshake bundle for piso_serializer.
// The master modport is the producer/consumer side and the slave modport is the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 2
) ();
  // Both streams use ready/valid handshakes. A transfer happens on a rising
  // edge where valid and ready are both high. Valid never waits for ready, and
  // the payload holds while valid is high and ready is low.
  logic [WIDTH-1:0] I;
  logic             I_valid;
  logic             I_ready;
  logic             O;
  logic             O_valid;
  logic             O_ready;
  logic             O_last;

  modport master (
    output I, I_valid, O_ready,
    input  I_ready, O, O_valid, O_last
  );

  modport slave (
    input  I, I_valid, O_ready,
    output I_ready, O, O_valid, O_last
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: loads one WIDTH-bit word and emits it LSB-first with O_last.
// Optional even-parity trailer beat is enabled by defining PISO_SERIALIZER_PARITY_EN.
module piso_serializer #(
  parameter int              WIDTH = 2,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  piso_serializer_if.slave bus,
  output logic [1:0]       o_dbg_state
);
  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1
`ifdef PISO_SERIALIZER_PARITY_EN
    ,S_PARITY = 2'd2
`endif
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_o_valid;
  logic             r_o_last;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             r_par;
`endif

  logic             w_at_last;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             w_load;
  logic             w_beat;

  assign w_at_last   = (r_cnt == LAST);
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
  assign w_beat      = r_o_valid & bus.O_ready;
  assign w_load      = bus.I_valid & bus.I_ready;

  // Ready opens during the accepted final beat so the next word loads with no bubble.
`ifdef PISO_SERIALIZER_PARITY_EN
  assign bus.I_ready = (r_state == S_IDLE) | ((r_state == S_PARITY) & bus.O_ready);
  assign bus.O       = (r_state == S_PARITY) ? r_par : r_shreg[0];
`else
  assign bus.I_ready = (r_state == S_IDLE) | ((r_state == S_SHIFT) & w_at_last & bus.O_ready);
  assign bus.O       = r_shreg[0];
`endif
  assign bus.O_valid = r_o_valid;
  assign bus.O_last  = r_o_last;
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_shreg   <= INIT;
      r_cnt     <= '0;
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else if (w_load) begin
      r_state   <= S_SHIFT;
      r_shreg   <= bus.I;
      r_cnt     <= '0;
      r_o_valid <= 1'b1;
      r_o_last  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      r_par     <= ^bus.I;
`endif
    end else if (w_beat) begin
      case (r_state)
        S_SHIFT: begin
          r_shreg <= w_shreg_nxt;
          if (w_at_last) begin
            r_cnt <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
            r_state  <= S_PARITY;
            r_o_last <= 1'b1;
`else
            r_state   <= S_IDLE;
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
`endif
          end else begin
            r_cnt <= w_cnt_nxt;
`ifdef PISO_SERIALIZER_PARITY_EN
            r_o_last <= 1'b0;
`else
            r_o_last <= (w_cnt_nxt == LAST);
`endif
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_o_valid <= 1'b0;
          r_o_last  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a WIDTH=4 instance and a WIDTH=2/INIT=01 instance,
// per-cycle vector table plus a beat scoreboard fed from accepted words.
module tb_piso_serializer;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rst4 = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(4)) if4 ();
  piso_serializer_if #(.WIDTH(2)) if2 ();
  logic [1:0] dbg4;
  logic [1:0] dbg2;

  piso_serializer #(.WIDTH(4), .INIT(4'b0000)) u_dut4 (
    .CLK(clk), .RESET(rst4), .bus(if4), .o_dbg_state(dbg4)
  );
  piso_serializer #(.WIDTH(2), .INIT(2'b01)) u_dut2 (
    .CLK(clk), .RESET(rst2), .bus(if2), .o_dbg_state(dbg2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit sel, input bit rst, input logic [3:0] i,
                       input bit iv, input bit ordy);
    rst4 = 1'b0; if4.I_valid = 1'b0; if4.O_ready = 1'b0;
    rst2 = 1'b0; if2.I_valid = 1'b0; if2.O_ready = 1'b0;
    if (sel) begin
      rst2 = rst; if2.I = i[1:0]; if2.I_valid = iv; if2.O_ready = ordy;
    end else begin
      rst4 = rst; if4.I = i; if4.I_valid = iv; if4.O_ready = ordy;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q4[$];
  logic [1:0] exp_q2[$];
  logic [1:0] e4;
  logic [1:0] e2;

  always @(negedge clk) begin
    if (rst4) exp_q4.delete();
    else begin
      if (if4.O_valid && if4.O_ready) begin
        if (exp_q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb4_extra_beat: got beat %b with nothing expected", {if4.O_last, if4.O});
        end else begin
          e4 = exp_q4.pop_front();
          chk("sb4_beat{last,bit}", {2'b00, if4.O_last, if4.O}, {2'b00, e4});
        end
      end
      if (if4.I_valid && if4.I_ready) begin
        for (int b = 0; b < 4; b++) exp_q4.push_back({(b == 3) && !PAR, if4.I[b]});
        if (PAR) exp_q4.push_back({1'b1, ^if4.I});
      end
    end
  end

  always @(negedge clk) begin
    if (rst2) exp_q2.delete();
    else begin
      if (if2.O_valid && if2.O_ready) begin
        if (exp_q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb2_extra_beat: got beat %b with nothing expected", {if2.O_last, if2.O});
        end else begin
          e2 = exp_q2.pop_front();
          chk("sb2_beat{last,bit}", {2'b00, if2.O_last, if2.O}, {2'b00, e2});
        end
      end
      if (if2.I_valid && if2.I_ready) begin
        for (int b = 0; b < 2; b++) exp_q2.push_back({(b == 1) && !PAR, if2.I[b]});
        if (PAR) exp_q2.push_back({1'b1, ^if2.I});
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit         sel;
    logic [3:0] i;
    bit         iv;
    bit         ordy;
    bit         e_ir;
    bit         e_o;
    bit         e_ov;
    bit         e_ol;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input bit sel, input logic [3:0] i, input bit iv, input bit ordy,
                              input bit e_ir, input bit e_o, input bit e_ov, input bit e_ol);
    vec_t v;
    v.sel = sel; v.i = i; v.iv = iv; v.ordy = ordy;
    v.e_ir = e_ir; v.e_o = e_o; v.e_ov = e_ov; v.e_ol = e_ol;
    vecs.push_back(v);
  endfunction

  task automatic check_outs(input bit sel, input string tag,
                            input bit e_ir, input bit e_o, input bit e_ov, input bit e_ol);
    if (sel) begin
      chk({tag, "_I_ready"}, {3'b0, if2.I_ready}, {3'b0, e_ir});
      chk({tag, "_O"},       {3'b0, if2.O},       {3'b0, e_o});
      chk({tag, "_O_valid"}, {3'b0, if2.O_valid}, {3'b0, e_ov});
      chk({tag, "_O_last"},  {3'b0, if2.O_last},  {3'b0, e_ol});
    end else begin
      chk({tag, "_I_ready"}, {3'b0, if4.I_ready}, {3'b0, e_ir});
      chk({tag, "_O"},       {3'b0, if4.O},       {3'b0, e_o});
      chk({tag, "_O_valid"}, {3'b0, if4.O_valid}, {3'b0, e_ov});
      chk({tag, "_O_last"},  {3'b0, if4.O_last},  {3'b0, e_ol});
    end
  endtask

  initial begin
    // ---- fill table: columns are sel, I, I_valid, O_ready | I_ready, O, O_valid, O_last
`ifdef PISO_SERIALIZER_PARITY_EN
    // WIDTH=2 back-to-back 10 then 01, each followed by a parity beat of 1
    add(1, 4'b0010, 1, 1,  1, 1, 0, 0);
    add(1, 4'b0001, 1, 1,  0, 0, 1, 0);
    add(1, 4'b0001, 1, 1,  0, 1, 1, 0);
    add(1, 4'b0001, 1, 1,  1, 1, 1, 1);
    add(1, 4'b0000, 0, 1,  0, 1, 1, 0);
    add(1, 4'b0000, 0, 1,  0, 0, 1, 0);
    add(1, 4'b0000, 0, 1,  1, 1, 1, 1);
    add(1, 4'b0000, 0, 1,  1, 0, 0, 0);
    // WIDTH=4: 0111 -> 1,1,1,0,parity 1 (stalled once), then 0011 -> parity 0
    add(0, 4'b0111, 1, 1,  1, 0, 0, 0);
    add(0, 4'b0000, 0, 1,  0, 1, 1, 0);
    add(0, 4'b0000, 0, 1,  0, 1, 1, 0);
    add(0, 4'b0000, 0, 1,  0, 1, 1, 0);
    add(0, 4'b0000, 0, 1,  0, 0, 1, 0);
    add(0, 4'b0011, 1, 0,  0, 1, 1, 1);
    add(0, 4'b0011, 1, 1,  1, 1, 1, 1);
    add(0, 4'b1111, 0, 1,  0, 1, 1, 0);
    add(0, 4'b1111, 0, 1,  0, 1, 1, 0);
    add(0, 4'b0000, 0, 1,  0, 0, 1, 0);
    add(0, 4'b0000, 0, 0,  0, 0, 1, 0);
    add(0, 4'b0000, 0, 1,  0, 0, 1, 0);
    add(0, 4'b0000, 0, 1,  1, 0, 1, 1);
    add(0, 4'b0000, 0, 1,  1, 0, 0, 0);
`else
    // WIDTH=2 back-to-back 10 then 01 -> 0,1,1,0 with no gap
    add(1, 4'b0010, 1, 1,  1, 1, 0, 0);
    add(1, 4'b0001, 1, 1,  0, 0, 1, 0);
    add(1, 4'b0001, 1, 1,  1, 1, 1, 1);
    add(1, 4'b0000, 0, 1,  0, 1, 1, 0);
    add(1, 4'b0000, 0, 1,  1, 0, 1, 1);
    add(1, 4'b0000, 0, 1,  1, 0, 0, 0);
    // WIDTH=4 basic 1011 -> 1,1,0,1
    add(0, 4'b1011, 1, 1,  1, 0, 0, 0);
    add(0, 4'b1011, 0, 1,  0, 1, 1, 0);
    add(0, 4'b0000, 0, 1,  0, 1, 1, 0);
    add(0, 4'b0000, 0, 1,  0, 0, 1, 0);
    add(0, 4'b0000, 0, 1,  1, 1, 1, 1);
    add(0, 4'b0000, 0, 1,  1, 0, 0, 0);
    // backpressure 0110: stall three cycles on bit 1
    add(0, 4'b0110, 1, 1,  1, 0, 0, 0);
    add(0, 4'b0000, 0, 1,  0, 0, 1, 0);
    add(0, 4'b0000, 0, 0,  0, 1, 1, 0);
    add(0, 4'b0000, 0, 0,  0, 1, 1, 0);
    add(0, 4'b0000, 0, 0,  0, 1, 1, 0);
    add(0, 4'b0000, 0, 1,  0, 1, 1, 0);
    add(0, 4'b0000, 0, 1,  0, 1, 1, 0);
    add(0, 4'b0000, 0, 1,  1, 0, 1, 1);
    add(0, 4'b0000, 0, 1,  1, 0, 0, 0);
    // stall on final beat with a word waiting, then back-to-back load; I changes after load
    add(0, 4'b1000, 1, 1,  1, 0, 0, 0);
    add(0, 4'b0000, 0, 1,  0, 0, 1, 0);
    add(0, 4'b0000, 0, 1,  0, 0, 1, 0);
    add(0, 4'b0000, 0, 1,  0, 0, 1, 0);
    add(0, 4'b0101, 1, 0,  0, 1, 1, 1);
    add(0, 4'b0101, 1, 1,  1, 1, 1, 1);
    add(0, 4'b1111, 0, 1,  0, 1, 1, 0);
    add(0, 4'b1111, 0, 1,  0, 0, 1, 0);
    add(0, 4'b1111, 0, 1,  0, 1, 1, 0);
    add(0, 4'b1111, 0, 1,  1, 0, 1, 1);
    add(0, 4'b0000, 0, 1,  1, 0, 0, 0);
`endif

    // ---- reset: both held for two edges, WIDTH=2 INIT=01 shows O=1
    if4.I = '0; if4.I_valid = 1'b0; if4.O_ready = 1'b0;
    if2.I = '0; if2.I_valid = 1'b0; if2.O_ready = 1'b0;
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin rst2 = 1'b0; rst4 = 1'b0; end
      @(negedge clk);
      check_outs(1, $sformatf("reset_c%0d", c), 1, 1, 0, 0);
      chk($sformatf("reset_c%0d_state2", c), {2'b0, dbg2}, 4'd0);
      chk($sformatf("reset_c%0d_O4", c), {3'b0, if4.O}, 4'd0);
      next_cycle();
    end

    // ---- table
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].sel, 1'b0, vecs[k].i, vecs[k].iv, vecs[k].ordy);
      @(negedge clk);
      check_outs(vecs[k].sel, $sformatf("vec%0d", k),
                 vecs[k].e_ir, vecs[k].e_o, vecs[k].e_ov, vecs[k].e_ol);
      next_cycle();
    end

    // ---- reset mid-word: 1111 loaded, one beat out, reset while O_valid high
    drive(0, 0, 4'b1111, 1, 1); next_cycle();
    drive(0, 0, 4'b0000, 0, 1);
    @(negedge clk);
    chk("midrst_state_shift", {2'b0, dbg4}, 4'd1);
    next_cycle();
    drive(0, 1, 4'b0000, 0, 1);
    @(negedge clk);
    chk("midrst_rstcyc_O_last", {3'b0, if4.O_last}, 4'd0);
    next_cycle();
    drive(0, 0, 4'b0000, 0, 0);
    @(negedge clk);
    check_outs(0, "midrst_after", 1, 0, 0, 0);
    chk("midrst_state_idle", {2'b0, dbg4}, 4'd0);
    next_cycle();
    drive(0, 0, 4'b0110, 1, 1); next_cycle();
    drive(0, 0, 4'b0000, 0, 1);
    @(negedge clk);
    check_outs(0, "midrst_newbit0", 0, 0, 1, 0);
    for (int c = 0; c < 5; c++) next_cycle();
    @(negedge clk);
    chk("midrst_new_done_O_valid", {3'b0, if4.O_valid}, 4'd0);

    // ---- random traffic on both instances, checked by the scoreboard
    for (int c = 0; c < 300; c++) begin
      if4.I = 4'($urandom_range(0, 15));
      if4.I_valid = ($urandom_range(0, 2) != 0);
      if4.O_ready = ($urandom_range(0, 3) != 0);
      if2.I = 2'($urandom_range(0, 3));
      if2.I_valid = ($urandom_range(0, 2) != 0);
      if2.O_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
    end

    // ---- drain and confirm every expected beat came out
    drive(0, 0, 4'b0000, 0, 1);
    if2.O_ready = 1'b1;
    for (int c = 0; c < 8; c++) next_cycle();
    chk("drain_q4_empty", 4'(exp_q4.size()), 4'd0);
    chk("drain_q2_empty", 4'(exp_q2.size()), 4'd0);
    @(negedge clk);
    chk("drain_O_valid4", {3'b0, if4.O_valid}, 4'd0);
    chk("drain_O_valid2", {3'b0, if2.O_valid}, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
